// File: rtl/data_mem_resp.sv
// Data-memory responder for the MEM-stage load/store port: one request at a time,
// WAIT_CYC wait states, then a one-cycle ack with load data from a word-wide RAM.
module data_mem_resp #(
    parameter int ADDR_W   = 10,
    parameter int WAIT_CYC = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_ce_i,
    input  logic        mem_we_i,
    input  logic [31:0] mem_addr_i,
    input  logic [3:0]  mem_sel_i,
    input  logic [31:0] mem_data_i,
    output logic [31:0] mem_data_o,
    output logic        mem_ack_o,
    output logic        stall_req_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACK
    } state_t;

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYC);
    localparam int         DEPTH     = 2 ** ADDR_W;

    state_t              state;
    state_t              state_nx;
    logic [3:0]          cnt;

    logic                req_we;
    logic [ADDR_W-1:0]   req_idx;
    logic [3:0]          req_sel;
    logic [31:0]         req_data;

    logic                do_access;
    logic                acc_we;
    logic [ADDR_W-1:0]   acc_idx;
    logic [3:0]          acc_sel;
    logic [31:0]         acc_data;

    logic [31:0]         ram [DEPTH];

    // Byte offset and high address bits are deliberately ignored, so addresses alias.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{mem_addr_i[31:ADDR_W+2], mem_addr_i[1:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        // NOTE: default first so every path assigns state_nx and no latch is inferred.
        state_nx = state;
        case (state)
            S_IDLE: if (mem_ce_i) state_nx = (WAIT_CYC == 0) ? S_ACK : S_WAIT;
            S_WAIT: if (cnt == 4'd1) state_nx = S_ACK;
            S_ACK:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // With zero wait states the access happens straight from IDLE, so it uses the live inputs.
    always_comb begin
        stall_req_o = !rst && ((state == S_IDLE && mem_ce_i) || state == S_WAIT);
        do_access   = !rst && ((state == S_IDLE && mem_ce_i && WAIT_CYC == 0) ||
                               (state == S_WAIT && cnt == 4'd1));
        if (state == S_IDLE) begin
            acc_we   = mem_we_i;
            acc_idx  = mem_addr_i[ADDR_W+1:2];
            acc_sel  = mem_sel_i;
            acc_data = mem_data_i;
        end else begin
            acc_we   = req_we;
            acc_idx  = req_idx;
            acc_sel  = req_sel;
            acc_data = req_data;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            cnt        <= 4'd0;
            req_we     <= 1'b0;
            req_idx    <= '0;
            req_sel    <= 4'd0;
            req_data   <= 32'd0;
            mem_ack_o  <= 1'b0;
            mem_data_o <= 32'd0;
        end else begin
            mem_ack_o  <= do_access;
            mem_data_o <= (do_access && !acc_we) ? ram[acc_idx] : 32'd0;
            if (state == S_IDLE && mem_ce_i) begin
                req_we   <= mem_we_i;
                req_idx  <= mem_addr_i[ADDR_W+1:2];
                req_sel  <= mem_sel_i;
                req_data <= mem_data_i;
                cnt      <= WAIT_INIT;
            end else if (state == S_WAIT && cnt != 4'd1) begin
                cnt <= cnt - 4'd1;
            end
        end
    end

    // NOTE: the RAM array has no reset; contents survive rst and only do_access (gated by rst) writes it.
    always_ff @(posedge clk) begin
        if (do_access && acc_we) begin
            for (int k = 0; k < 4; k++) begin
                if (acc_sel[k]) ram[acc_idx][8*k +: 8] <= acc_data[8*k +: 8];
            end
        end
    end

endmodule
